// File: rtl/event_cdc_pkg.sv
// Shared types and sizing helpers for the event CDC sequencer.
package event_cdc_pkg;

    localparam int unsigned HoldCycDefault = 3;
    localparam int unsigned GapCycDefault  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    // Counter must hold max(hold, gap) - 1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned mx;
        mx = (hold > gap) ? hold : gap;
        return ($clog2(mx + 1) < 1) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/event_cdc_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request above last_grant, with wrap.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [ID_W-1:0]  grant_o,
    output logic             valid_o
);

    always_comb begin : p_arb
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        // Walk from the farthest offset down so the nearest one above last_grant wins.
        for (int i = int'(N_REQ); i >= 1; i--) begin
            idx = (int'(last_grant_i) + i) % int'(N_REQ);
            if (req_i[idx]) begin
                grant_o = ID_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_cdc_sequencer.sv
// Shares one pulse-synchronizer channel among N_REQ requesters: latch, arbitrate,
// then emit a HOLD_CYC-wide pulse plus a GAP_CYC low gap with a stable event ID.
module event_cdc_sequencer
    import event_cdc_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_CYC = HoldCycDefault,
    parameter int unsigned GAP_CYC  = GapCycDefault,
    parameter int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ovf_clr,
    output logic             tx_pulse,
    output logic [ID_W-1:0]  tx_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] ovf
);

    localparam int unsigned CntW = cnt_width(HOLD_CYC, GAP_CYC);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   tx_id_q, tx_id_d;
    logic              tx_pulse_q, tx_pulse_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  ovf_q, ovf_d;
    logic [N_REQ-1:0]  clr;
    logic [ID_W-1:0]   arb_grant;
    logic              arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req_i        (pending_q),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        tx_id_d      = tx_id_q;
        tx_pulse_d   = tx_pulse_q;
        busy_d       = busy_q;
        clr          = '0;

        unique case (state_q)
            StIdle: begin
                tx_pulse_d = 1'b0;
                if (arb_valid) begin
                    state_d         = StHold;
                    tx_pulse_d      = 1'b1;
                    tx_id_d         = arb_grant;
                    busy_d          = 1'b1;
                    clr[arb_grant]  = 1'b1;
                    last_grant_d    = arb_grant;
                    cnt_d           = CntW'(HOLD_CYC - 1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d    = StGap;
                    tx_pulse_d = 1'b0;
                    cnt_d      = CntW'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                tx_pulse_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // A request coinciding with its own grant clear re-arms the bit (set wins).
        pending_d = (pending_q & ~clr) | req_pulse;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (req_pulse & pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            tx_id_q      <= '0;
            tx_pulse_q   <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            tx_id_q      <= tx_id_d;
            tx_pulse_q   <= tx_pulse_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
        end
    end

    assign tx_pulse = tx_pulse_q;
    assign tx_id    = tx_id_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_event_cdc_sequencer.sv
// Directed self-checking bench for event_cdc_sequencer (N_REQ=4, HOLD=GAP=3).
module tb_event_cdc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_pulse = '0;
    logic       ovf_clr = 1'b0;
    logic       tx_pulse;
    logic [1:0] tx_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] ovf;

    int n_checks = 0;
    int n_errors = 0;

    event_cdc_sequencer #(
        .N_REQ    (4),
        .HOLD_CYC (3),
        .GAP_CYC  (3),
        .ID_W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .ovf_clr   (ovf_clr),
        .tx_pulse  (tx_pulse),
        .tx_id     (tx_id),
        .busy      (busy),
        .pending   (pending),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges; return 1 ns after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_pulse = '0;
        ovf_clr   = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned ids3 [3];
        int unsigned ids4 [4];
        int phase, k;

        // Reset values
        do_reset();
        check("rst_tx_pulse", 32'(tx_pulse), 0);
        check("rst_tx_id",    32'(tx_id),    0);
        check("rst_busy",     32'(busy),     0);
        check("rst_pending",  32'(pending),  0);
        check("rst_ovf",      32'(ovf),      0);

        // Single event: requester 2
        req_pulse = 4'b0100;
        tick();
        req_pulse = '0;
        check("single_pending_set", 32'(pending), 32'h4);
        check("single_pulse_pre",   32'(tx_pulse), 0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("single_pulse_c%0d", c), 32'(tx_pulse), (c <= 3) ? 1 : 0);
            check($sformatf("single_busy_c%0d", c), 32'(busy), (c <= 6) ? 1 : 0);
            check($sformatf("single_id_c%0d", c), 32'(tx_id), 2);
            if (c == 1) check("single_pending_clr", 32'(pending), 0);
        end

        // Simultaneous requests 1011 -> IDs 0, 1, 3 every 7 cycles
        do_reset();
        ids3 = '{0, 1, 3};
        req_pulse = 4'b1011;
        tick();
        req_pulse = '0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            k     = (c - 1) / 7;
            phase = (c - 1) % 7;
            if (k < 3) begin
                check($sformatf("simul_pulse_c%0d", c), 32'(tx_pulse), (phase < 3) ? 1 : 0);
                check($sformatf("simul_busy_c%0d", c), 32'(busy), (phase < 6) ? 1 : 0);
                if (phase < 6) check($sformatf("simul_id_c%0d", c), 32'(tx_id), ids3[k]);
            end else begin
                check($sformatf("simul_idle_c%0d", c), 32'(busy), 0);
            end
        end
        check("simul_ovf", 32'(ovf), 0);

        // Fairness: 0 and 1 re-request every cycle -> 0,1,0,1
        do_reset();
        ids4 = '{0, 1, 0, 1};
        req_pulse = 4'b0011;
        tick();
        for (int c = 1; c <= 22; c++) begin
            tick();
            if ((c - 1) % 7 == 0) begin
                check($sformatf("fair_pulse_c%0d", c), 32'(tx_pulse), 1);
                check($sformatf("fair_id_c%0d", c), 32'(tx_id), ids4[(c - 1) / 7]);
            end
        end
        req_pulse = '0;

        // Coalescing: two requests from 1 during a busy period -> one event, ovf[1]
        do_reset();
        req_pulse = 4'b0001;
        tick();                 // E0
        req_pulse = '0;
        tick();                 // E1: grant 0
        check("coal_id0", 32'(tx_id), 0);
        req_pulse = 4'b0010;
        tick();                 // E2
        req_pulse = '0;
        check("coal_pending1", 32'(pending), 32'h2);
        check("coal_ovf_none", 32'(ovf), 0);
        tick();                 // E3
        req_pulse = 4'b0010;
        tick();                 // E4
        req_pulse = '0;
        check("coal_ovf_set", 32'(ovf), 32'h2);
        check("coal_pending_one", 32'(pending), 32'h2);
        tick(4);                // E8: grant 1
        check("coal_id1", 32'(tx_id), 1);
        check("coal_pulse1", 32'(tx_pulse), 1);
        check("coal_pending_clr", 32'(pending), 0);
        tick(7);                // E15: nothing further
        check("coal_no_repeat_busy", 32'(busy), 0);
        tick();
        check("coal_no_repeat_pulse", 32'(tx_pulse), 0);
        check("coal_ovf_sticky", 32'(ovf), 32'h2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("coal_ovf_clr", 32'(ovf), 0);

        // Set-wins race: request 2 again on its grant cycle
        do_reset();
        req_pulse = 4'b0100;
        tick(2);                // sampled at E0 and E1 (grant edge)
        req_pulse = '0;
        check("race_id_first", 32'(tx_id), 2);
        check("race_pending_kept", 32'(pending), 32'h4);
        check("race_ovf_first", 32'(ovf), 0);
        tick(7);                // E8: second grant
        check("race_id_second", 32'(tx_id), 2);
        check("race_pulse_second", 32'(tx_pulse), 1);
        check("race_pending_done", 32'(pending), 0);
        check("race_ovf_final", 32'(ovf), 0);

        // Async reset mid-HOLD
        do_reset();
        req_pulse = 4'b0101;
        tick();                 // E0
        req_pulse = 4'b0100;
        tick();                 // E1: grant 0, ovf[2] set
        req_pulse = '0;
        check("ares_pulse_pre", 32'(tx_pulse), 1);
        check("ares_ovf_pre", 32'(ovf), 32'h4);
        check("ares_pending_pre", 32'(pending), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("ares_pulse", 32'(tx_pulse), 0);
        check("ares_busy", 32'(busy), 0);
        check("ares_pending", 32'(pending), 0);
        check("ares_ovf", 32'(ovf), 0);
        #2;
        rst = 1'b0;
        tick();
        req_pulse = 4'b0011;
        tick();
        req_pulse = '0;
        check("ares_pending_new", 32'(pending), 32'h3);
        tick();
        check("ares_first_id", 32'(tx_id), 0);
        check("ares_first_pulse", 32'(tx_pulse), 1);
        tick(7);
        check("ares_second_id", 32'(tx_id), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
